// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with alignment/width checks, byte lanes, sign extension and a memory timeout
module lsu #(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, next;
  logic [OW-1:0] off, off_q;
  logic [1:0] sz, sz_q;
  logic uns_q, st_q, legal, bad, tmo, sign;
  logic [CW-1:0] cnt;
  logic [NB-1:0] be;
  logic [XLEN-1:0] wrep, shifted, mask, ext;
  always_comb begin
    off = req_addr[OW-1:0];
    sz = req_funct3[1:0];
    legal = req_store ? (req_funct3 <= 3'd2 || (req_funct3 == 3'd3 && XLEN == 64))
                      : (req_funct3 != 3'd7 && (XLEN == 64 || (req_funct3 != 3'd3 && req_funct3 != 3'd6)));
    bad = !legal || |(off & OW'((1 << sz) - 1));
    be = NB'((1 << (1 << sz)) - 1) << off;
    wrep = '0;
    for (int i = 0; i < NB; i++) wrep[8*i +: 8] = req_wdata[8*(i & ((1 << sz) - 1)) +: 8];
    shifted = dmem_rdata >> {off_q, 3'b000};
    mask = sz_q == 2'(OW) ? '1 : ~({XLEN{1'b1}} << (8 << sz_q));
    // top bit of the access width, found without a variable bit index
    sign = |(shifted & mask & ~(mask >> 1));
    ext = (shifted & mask) | ((!uns_q && sign) ? ~mask : '0);
    tmo = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    next = state == IDLE ? (req_valid ? (bad ? RESP : REQ) : IDLE)
         : state == REQ  ? ((dmem_ack || tmo) ? RESP : REQ)
         : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rd <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      off_q <= '0;
      sz_q <= '0;
      uns_q <= 1'b0;
      st_q <= 1'b0;
      cnt <= '0;
    end else begin
      req_ready <= next == IDLE;
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        st_q <= req_store;
        off_q <= off;
        sz_q <= sz;
        uns_q <= req_funct3[2];
        cnt <= '0;
        resp_rd <= req_store ? '0 : req_rd;
        if (bad) begin
          resp_valid <= 1'b1;
          resp_err <= 1'b1;
          resp_data <= '0;
        end else begin
          dmem_req <= 1'b1;
          dmem_we <= req_store;
          dmem_addr <= {req_addr[XLEN-1:OW], OW'(0)};
          dmem_be <= req_store ? be : '1;
          dmem_wdata <= req_store ? wrep : '0;
        end
      end else if (state == REQ) begin
        // an ack arriving in the final timeout cycle still completes normally
        if (dmem_ack || tmo) begin
          dmem_req <= 1'b0;
          resp_valid <= 1'b1;
          resp_err <= !dmem_ack || dmem_err;
          resp_data <= (dmem_ack && !dmem_err && !st_q) ? ext : '0;
        end else cnt <= cnt + 1'b1;
      end else if (state == RESP) resp_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu; randomized XLEN=32 traffic plus directed XLEN=64 accesses
module tb_lsu;
  logic clk = 0, rst = 1, rst_w = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  bit manual = 0, done64 = 0;

  logic req_valid, req_ready, req_store, resp_valid, resp_err, dmem_req, dmem_we, dmem_ack, dmem_err;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, resp_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0] req_rd, resp_rd;
  logic [3:0] dmem_be;

  lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err));

  logic w_req_valid, w_req_ready, w_req_store, w_resp_valid, w_resp_err, w_dmem_req, w_dmem_we, w_dmem_ack, w_dmem_err;
  logic [2:0] w_req_funct3;
  logic [63:0] w_req_addr, w_req_wdata, w_resp_data, w_dmem_addr, w_dmem_wdata, w_dmem_rdata;
  logic [4:0] w_req_rd, w_resp_rd;
  logic [7:0] w_dmem_be;

  lsu #(.XLEN(64), .TIMEOUT(0)) dut64 (
    .clk(clk), .rst(rst_w), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_store(w_req_store),
    .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_rd(w_req_rd),
    .resp_valid(w_resp_valid), .resp_rd(w_resp_rd), .resp_data(w_resp_data), .resp_err(w_resp_err),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_addr(w_dmem_addr), .dmem_be(w_dmem_be),
    .dmem_wdata(w_dmem_wdata), .dmem_ack(w_dmem_ack), .dmem_rdata(w_dmem_rdata), .dmem_err(w_dmem_err));

  typedef struct { logic [31:0] addr, wdata, rdata; logic we, err; logic [3:0] be; int lat; } mem_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic err; int edge_; } rsp_t;
  mem_t mq[$];
  rsp_t rq[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bad_event(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic bit legal32(bit st, logic [2:0] f3);
    return st ? (f3 <= 3'd2) : (f3 != 3'd7 && f3 != 3'd3 && f3 != 3'd6);
  endfunction

  function automatic logic [31:0] ld32(logic [2:0] f3, int off, logic [31:0] rdata);
    int s = 1 << f3[1:0];
    longint v = 0;
    for (int b = 0; b < s; b++) v += longint'((rdata >> (8 * (off + b))) & 32'hFF) << (8 * b);
    if (!f3[2] && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
    return v[31:0];
  endfunction

  function automatic logic [3:0] be32(int s, int off);
    logic [3:0] r = '0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + s) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rep32(int s, logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(b % s) +: 8];
    return r;
  endfunction

  task automatic issue(bit st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata, logic [4:0] rd,
                       int lat, logic [31:0] rdata, bit err);
    int s, off, n, e;
    bit ok;
    mem_t m;
    rsp_t r;
    @(negedge clk);
    req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin bad_event("accept_wait_expired"); req_valid = 0; return; end
    @(posedge clk);
    #1 e = cyc;
    s = 1 << f3[1:0];
    off = int'(addr % 4);
    ok = legal32(st, f3) && (addr % s) == 0;
    r.rd = st ? 5'd0 : rd;
    if (!ok) begin
      r.data = 0; r.err = 1; r.edge_ = e;
    end else begin
      m.addr = addr & ~32'd3; m.we = st; m.be = st ? be32(s, off) : 4'hF;
      m.wdata = rep32(s, wdata); m.lat = lat; m.rdata = rdata; m.err = err;
      mq.push_back(m);
      if (lat == 0 || lat > 4) begin
        r.data = 0; r.err = 1; r.edge_ = e + 4;
      end else begin
        r.err = err; r.data = (st || err) ? 32'd0 : ld32(f3, off, rdata); r.edge_ = e + lat;
      end
    end
    rq.push_back(r);
  endtask

  // memory responder: checks each request against the expected transaction and acks after its latency
  initial begin
    mem_t m;
    dmem_ack = 0; dmem_err = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      if (manual || !dmem_req) begin
        dmem_ack = manual ? 1'b0 : 1'($urandom % 2);
        dmem_err = 1'($urandom % 2);
        dmem_rdata = $urandom;
        continue;
      end
      if (mq.size() == 0) begin bad_event("dmem_req_unexpected"); dmem_ack = 0; continue; end
      m = mq.pop_front();
      for (int c = 1; ; c++) begin
        chk("dmem_req_held", dmem_req, 1);
        chk("dmem_addr", dmem_addr, m.addr);
        chk("dmem_we", dmem_we, m.we);
        chk("dmem_be", dmem_be, m.be);
        if (m.we) chk("dmem_wdata", dmem_wdata, m.wdata);
        dmem_ack = (c == m.lat);
        dmem_err = m.err;
        dmem_rdata = (c == m.lat) ? m.rdata : $urandom;
        @(posedge clk);
        if (c == m.lat || c == 4) break;
        @(negedge clk);
      end
      @(negedge clk);
      chk("dmem_req_drop", dmem_req, 0);
      dmem_ack = 1'($urandom % 2);
      dmem_err = 1'($urandom % 2);
    end
  end

  // response monitor: pops the scoreboard on every completion pulse
  initial begin
    rsp_t r;
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        chk("resp_single_cycle", prev, 0);
        if (rq.size() == 0) bad_event("resp_valid_unexpected");
        else begin
          r = rq.pop_front();
          chk("resp_rd", resp_rd, r.rd);
          chk("resp_data", resp_data, r.data);
          chk("resp_err", resp_err, r.err);
          chk("resp_cycle", cyc, r.edge_);
        end
      end
      prev = resp_valid;
    end
  end

  task automatic do64(bit st, logic [2:0] f3, logic [63:0] addr, logic [63:0] wdata, logic [63:0] rdata, int lat,
                      logic [63:0] e_addr, logic [7:0] e_be, logic [63:0] e_wdata, logic [63:0] e_data);
    int n;
    @(negedge clk);
    w_req_store = st; w_req_funct3 = f3; w_req_addr = addr; w_req_wdata = wdata; w_req_rd = 5'd12; w_req_valid = 1;
    n = 0;
    while (!w_req_ready && n < 100) begin @(negedge clk); n++; end
    if (!w_req_ready) begin bad_event("w_accept_wait_expired"); w_req_valid = 0; return; end
    @(posedge clk);
    #1 w_req_valid = 0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("w_dmem_req", w_dmem_req, 1);
      if (c == 1) begin
        chk("w_dmem_addr", w_dmem_addr, e_addr);
        chk("w_dmem_we", w_dmem_we, st);
        chk("w_dmem_be", w_dmem_be, e_be);
        if (st) chk("w_dmem_wdata", w_dmem_wdata, e_wdata);
      end
      w_dmem_ack = (c == lat);
      w_dmem_rdata = rdata;
    end
    @(negedge clk);
    w_dmem_ack = 0;
    chk("w_resp_valid", w_resp_valid, 1);
    chk("w_resp_data", w_resp_data, e_data);
    chk("w_resp_err", w_resp_err, 0);
    chk("w_resp_rd", w_resp_rd, st ? 5'd0 : 5'd12);
  endtask

  initial begin
    w_req_valid = 0; w_req_store = 0; w_req_funct3 = 0; w_req_addr = 0; w_req_wdata = 0; w_req_rd = 0;
    w_dmem_ack = 0; w_dmem_err = 0; w_dmem_rdata = 0;
    #1 rst_w = 0;
    repeat (2) @(negedge clk);
    chk("w_reset_ready", w_req_ready, 1);
    chk("w_reset_dmem_req", w_dmem_req, 0);
    rst_w = 1;
    do64(0, 3'd6, 64'hC, 0, 64'hF0000000_12345678, 1, 64'h8, 8'hFF, 0, 64'h00000000_F0000000);
    do64(0, 3'd2, 64'hC, 0, 64'hF0000000_12345678, 1, 64'h8, 8'hFF, 0, 64'hFFFFFFFF_F0000000);
    do64(0, 3'd3, 64'h8, 0, 64'h81234567_89ABCDEF, 2, 64'h8, 8'hFF, 0, 64'h81234567_89ABCDEF);
    do64(0, 3'd1, 64'h6, 0, 64'h8001_0000_0000_0000, 1, 64'h0, 8'hFF, 0, 64'hFFFFFFFF_FFFF8001);
    do64(1, 3'd3, 64'h10, 64'h01020304_05060708, 0, 1, 64'h10, 8'hFF, 64'h01020304_05060708, 0);
    do64(1, 3'd2, 64'h14, 64'hDEADBEEF_89ABCDEF, 0, 1, 64'h10, 8'hF0, 64'h89ABCDEF_89ABCDEF, 0);
    do64(0, 3'd2, 64'h20, 0, 64'h00000000_7FFFFFFF, 20, 64'h20, 8'hFF, 0, 64'h00000000_7FFFFFFF);
    done64 = 1;
  end

  initial begin
    int n;
    req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    #1 rst = 0;
    #2;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_dmem_req", dmem_req, 0);
    chk("reset_resp_err", resp_err, 0);
    @(negedge clk);
    rst = 1;
    issue(0, 3'd2, 32'h104, 0, 5'd5, 1, 32'hDEADBEEF, 0);
    issue(0, 3'd0, 32'h103, 0, 5'd6, 2, 32'h80123456, 0);
    issue(0, 3'd4, 32'h103, 0, 5'd7, 1, 32'h80123456, 0);
    issue(1, 3'd1, 32'h202, 32'h1234ABCD, 5'd9, 1, 0, 0);
    issue(0, 3'd2, 32'h102, 0, 5'd3, 1, 0, 0);
    issue(0, 3'd3, 32'h100, 0, 5'd4, 1, 0, 0);
    issue(1, 3'd3, 32'h100, 32'h55, 5'd4, 1, 0, 0);
    issue(0, 3'd7, 32'h100, 0, 5'd4, 1, 0, 0);
    issue(0, 3'd2, 32'h108, 0, 5'd8, 0, 0, 0);
    issue(0, 3'd2, 32'h108, 0, 5'd8, 4, 32'h11223344, 0);
    issue(0, 3'd2, 32'h10C, 0, 5'd10, 2, 32'h55, 1);
    issue(1, 3'd2, 32'h10C, 32'h99, 5'd11, 1, 0, 1);
    issue(0, 3'd5, 32'h10E, 0, 5'd2, 3, 32'h9ABC0000, 0);
    for (int i = 0; i < 150; i++)
      issue(1'($urandom % 2), 3'($urandom % 8), 32'h1000 + ($urandom % 64), $urandom, 5'($urandom),
            int'($urandom_range(0, 5)), $urandom, ($urandom % 4) == 0);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while ((rq.size() != 0 || mq.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (rq.size() != 0 || mq.size() != 0) bad_event("drain_expired");
    repeat (3) @(negedge clk);
    manual = 1;
    chk("idle_before_abort", req_ready, 1);
    req_store = 0; req_funct3 = 3'd2; req_addr = 32'h104; req_rd = 5'd5; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("abort_req_up", dmem_req, 1);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("abort_dmem_req", dmem_req, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_dmem_be", dmem_be, 0);
    @(negedge clk);
    rst = 1;
    repeat (6) @(negedge clk);
    chk("post_abort_ready", req_ready, 1);
    chk("post_abort_dmem_req", dmem_req, 0);
    manual = 0;
    n = 0;
    while (!done64 && n < 500) begin @(negedge clk); n++; end
    if (!done64) bad_event("xlen64_sequence_expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
